// File: rtl/sm_scoreboard.sv
// rtl/sm_scoreboard.sv - register-dependency scoreboard for variable-latency issue
//
// Tracks pending register writes and register-file writeback reservations
// beside the decode stage, producing stall and bypass-select flags and
// allowing the instruction accepted in the previous cycle to be cancelled.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid                 decode requests issue of an instruction
//   iss_rs/iss_rt, *_used     source registers and whether they are read
//   iss_wr, iss_rd, iss_lat   destination write enable, register, latency
//   kill_last                 cancel the instruction accepted last cycle
//   stall                     issue refused this cycle
//   fwd_rs, fwd_rt            operand comes from the bypass network
//   busy                      pending-write vector, one bit per register
//   wb_valid, wb_reg          tracked write retiring this cycle
module sm_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 8,
  parameter int LW      = 4,
  parameter int BYP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rs,
  input  logic [AW-1:0]    iss_rt,
  input  logic             iss_rs_used,
  input  logic             iss_rt_used,
  input  logic             iss_wr,
  input  logic [AW-1:0]    iss_rd,
  input  logic [LW-1:0]    iss_lat,
  input  logic             kill_last,
  output logic             stall,
  output logic             fwd_rs,
  output logic             fwd_rt,
  output logic [NREGS-1:0] busy,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_reg
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [LW-1:0]    rem_q [NREGS];
  logic [LW-1:0]    rem_d [NREGS];
  // slot_q[k] marks a reservation whose owner will have rem = k+1 next
  // cycle's view, i.e. it retires k cycles after the following edge. The
  // retiring entry itself (rem = 1) needs no slot bit.
  logic [MAX_LAT:1] slot_q, slot_d, slot_k;
  logic             li_v_q, li_v_d;
  logic [AW-1:0]    li_rd_q, li_rd_d;
  logic [LW-1:0]    li_age_q, li_age_d;

  logic [LW-1:0] lat_c;
  logic          slot_at_l;
  logic          rs_pend, rt_pend, wr_track;
  logic          raw_rs, raw_rt, waw, port;
  logic          hazard, fire, kill_hit;
  logic          wb_hit;
  logic [AW-1:0] wb_idx;

  // Latency clamped into 1..MAX_LAT.
  always_comb begin
    lat_c = iss_lat;
    if (iss_lat == '0) begin
      lat_c = LW'(1);
    end else if (iss_lat > LW'(MAX_LAT)) begin
      lat_c = LW'(MAX_LAT);
    end
  end

  always_comb begin
    slot_at_l = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (lat_c == LW'(k)) slot_at_l = slot_q[k];
    end
  end

  // Hazard checks use pre-kill state, so a same-cycle kill never unblocks.
  always_comb begin
    rs_pend  = (iss_rs != '0) && pend_q[iss_rs];
    rt_pend  = (iss_rt != '0) && pend_q[iss_rt];
    wr_track = iss_wr && (iss_rd != '0);
    raw_rs   = iss_rs_used && rs_pend && (rem_q[iss_rs] > LW'(BYP));
    raw_rt   = iss_rt_used && rt_pend && (rem_q[iss_rt] > LW'(BYP));
    fwd_rs   = iss_rs_used && rs_pend && (rem_q[iss_rs] <= LW'(BYP));
    fwd_rt   = iss_rt_used && rt_pend && (rem_q[iss_rt] <= LW'(BYP));
    // A write retiring this cycle does not block a new write to its register.
    waw      = wr_track && pend_q[iss_rd] && (rem_q[iss_rd] != LW'(1));
    port     = wr_track && slot_at_l;
    hazard   = raw_rs || raw_rt || waw || port;
    stall    = !rst && iss_valid && hazard;
    fire     = !rst && iss_valid && !hazard;
    kill_hit = kill_last && li_v_q;
  end

  // The slot rule guarantees at most one entry with rem = 1.
  always_comb begin
    wb_hit = 1'b0;
    wb_idx = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (pend_q[i] && (rem_q[i] == LW'(1))) begin
        wb_hit = 1'b1;
        wb_idx = AW'(i);
      end
    end
    wb_valid = !rst && wb_hit;
    wb_reg   = rst ? '0 : wb_idx;
    busy     = rst ? '0 : pend_q;
  end

  always_comb begin
    pend_d   = pend_q;
    rem_d    = rem_q;
    slot_k   = slot_q;
    li_v_d   = 1'b0;
    li_rd_d  = li_rd_q;
    li_age_d = li_age_q;

    for (int i = 1; i < NREGS; i++) begin
      if (pend_q[i]) begin
        rem_d[i] = rem_q[i] - LW'(1);
        if (rem_q[i] == LW'(1)) pend_d[i] = 1'b0;
      end
    end

    // Kill acts on the current slot view, before this edge's shift.
    if (kill_hit) begin
      pend_d[li_rd_q] = 1'b0;
      rem_d[li_rd_q]  = '0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (li_age_q == LW'(k)) slot_k[k] = 1'b0;
      end
    end

    slot_d = {1'b0, slot_k[MAX_LAT:2]};

    // The new issue is recorded after the kill so it survives it.
    if (fire && wr_track) begin
      pend_d[iss_rd] = 1'b1;
      rem_d[iss_rd]  = lat_c;
      for (int k = 1; k <= MAX_LAT; k++) begin
        if ((lat_c - LW'(1)) == LW'(k)) slot_d[k] = 1'b1;
      end
      li_v_d   = 1'b1;
      li_rd_d  = iss_rd;
      li_age_d = lat_c - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      slot_q   <= '0;
      li_v_q   <= 1'b0;
      li_rd_q  <= '0;
      li_age_q <= '0;
      for (int i = 0; i < NREGS; i++) rem_q[i] <= '0;
    end else begin
      pend_q   <= pend_d;
      slot_q   <= slot_d;
      li_v_q   <= li_v_d;
      li_rd_q  <= li_rd_d;
      li_age_q <= li_age_d;
      for (int i = 0; i < NREGS; i++) rem_q[i] <= rem_d[i];
    end
  end

endmodule

// File: tb/tb_sm_scoreboard.sv
// tb/tb_sm_scoreboard.sv - self-checking bench for sm_scoreboard
module tb_sm_scoreboard;

  localparam int NREGS = 32;
  localparam int BYP   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        iss_rs_used, iss_rt_used, iss_wr;
  logic [3:0]  iss_lat;
  logic        kill_last;
  logic        stall, fwd_rs, fwd_rt, wb_valid;
  logic [31:0] busy;
  logic [4:0]  wb_reg;

  sm_scoreboard dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid),
    .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_rs_used(iss_rs_used), .iss_rt_used(iss_rt_used),
    .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .kill_last(kill_last), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .busy(busy), .wb_valid(wb_valid), .wb_reg(wb_reg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference: each pending register remembers the absolute cycle in
  // which its write is reported on the writeback port.
  bit m_pend [NREGS];
  int m_ret  [NREGS];
  int now = 0;
  bit m_liv  = 1'b0;
  int m_lird = 0;

  logic        s_stall, s_fwd_rs, s_fwd_rt, s_wbv;
  logic [31:0] s_busy;
  logic [4:0]  s_wbr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int remaining(input int r);
    return m_ret[r] - now + 1;
  endfunction

  task automatic step(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                      input bit wr, input int rd, input int lat, input bit kill, input bit rst_in);
    int lc;
    bit wt, e_raw_rs, e_raw_rt, e_fwd_rs, e_fwd_rt, e_waw, e_port, e_stall, e_wbv, fire;
    logic [31:0] e_busy;
    int e_wbr;
    iss_valid = v; iss_rs = rs[4:0]; iss_rs_used = rsu; iss_rt = rt[4:0]; iss_rt_used = rtu;
    iss_wr = wr; iss_rd = rd[4:0]; iss_lat = lat[3:0]; kill_last = kill; rst = rst_in;
    @(negedge clk);
    lc = (lat == 0) ? 1 : ((lat > 8) ? 8 : lat);
    wt = wr && (rd != 0);
    e_raw_rs = rsu && (rs != 0) && m_pend[rs] && (remaining(rs) > BYP);
    e_raw_rt = rtu && (rt != 0) && m_pend[rt] && (remaining(rt) > BYP);
    e_fwd_rs = rsu && (rs != 0) && m_pend[rs] && (remaining(rs) <= BYP);
    e_fwd_rt = rtu && (rt != 0) && m_pend[rt] && (remaining(rt) <= BYP);
    e_waw = wt && m_pend[rd] && (remaining(rd) != 1);
    e_port = 1'b0;
    e_busy = '0;
    e_wbv = 1'b0;
    e_wbr = 0;
    for (int r = 1; r < NREGS; r++) begin
      if (m_pend[r]) begin
        if (wt && (m_ret[r] == now + lc)) e_port = 1'b1;
        if (!rst_in) e_busy[r] = 1'b1;
        if (!rst_in && m_ret[r] == now) begin
          e_wbv = 1'b1;
          e_wbr = r;
        end
      end
    end
    e_stall = !rst_in && v && (e_raw_rs || e_raw_rt || e_waw || e_port);
    s_stall = stall; s_fwd_rs = fwd_rs; s_fwd_rt = fwd_rt;
    s_busy = busy; s_wbv = wb_valid; s_wbr = wb_reg;
    check("stall", 32'(stall), 32'(e_stall));
    check("fwd_rs", 32'(fwd_rs), 32'(e_fwd_rs));
    check("fwd_rt", 32'(fwd_rt), 32'(e_fwd_rt));
    check("busy", busy, e_busy);
    check("wb_valid", 32'(wb_valid), 32'(e_wbv));
    if (e_wbv || rst_in) check("wb_reg", 32'(wb_reg), 32'(e_wbr));
    fire = v && !e_stall && !rst_in;
    if (rst_in) begin
      for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
      m_liv = 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) if (m_pend[r] && m_ret[r] == now) m_pend[r] = 1'b0;
      if (kill && m_liv) m_pend[m_lird] = 1'b0;
      if (fire && wt) begin
        m_pend[rd] = 1'b1;
        m_ret[rd]  = now + lc;
        m_lird     = rd;
      end
      m_liv = fire && wt;
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    for (int r = 0; r < NREGS; r++) begin
      m_pend[r] = 1'b0;
      m_ret[r]  = 0;
    end
    rst = 1'b1; iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rs_used = 0; iss_rt_used = 0;
    iss_wr = 0; iss_rd = 0; iss_lat = 0; kill_last = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 2, 1, 1, 3, 4, 0, 1);
    check("rst_busy", s_busy, 32'h0);
    check("rst_stall", 32'(s_stall), 32'h0);

    // L=1 producer, consumer next cycle
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 1, 0, 0);
    check("b2b_stall", 32'(s_stall), 32'h0);
    check("b2b_fwd", 32'(s_fwd_rs), 32'h1);
    check("b2b_wbv", 32'(s_wbv), 32'h1);
    check("b2b_wbr", 32'(s_wbr), 32'h3);
    idle(2);

    // Load r5 L=3, immediate consumer
    step(1, 0, 0, 0, 0, 1, 5, 3, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    check("ld_stall0", 32'(s_stall), 32'h1);
    step(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    check("ld_stall1", 32'(s_stall), 32'h1);
    step(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    check("ld_issue", 32'(s_stall), 32'h0);
    check("ld_fwd", 32'(s_fwd_rs), 32'h1);
    idle(3);

    // Writeback port conflict
    step(1, 0, 0, 0, 0, 1, 2, 4, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 1, 7, 2, 0, 0);
    check("port_stall", 32'(s_stall), 32'h1);
    step(1, 0, 0, 0, 0, 1, 7, 2, 0, 0);
    check("port_issue", 32'(s_stall), 32'h0);
    idle(4);

    // WAW until rem[4] = 1
    step(1, 0, 0, 0, 0, 1, 4, 5, 0, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 1, 4, 2, 0, 0);
      if (!s_stall) break;
      cnt++;
    end
    check("waw_stalls", 32'(cnt), 32'd4);
    idle(4);

    // Kill the last issue
    step(1, 0, 0, 0, 0, 1, 6, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("kill_busy6", 32'(s_busy[6]), 32'h0);
    step(1, 0, 0, 0, 0, 1, 8, 3, 0, 0);
    check("kill_next", 32'(s_stall), 32'h0);
    idle(6);

    // Reset mid-operation
    step(1, 0, 0, 0, 0, 1, 9, 8, 0, 0);
    step(1, 0, 0, 0, 0, 1, 10, 6, 0, 0);
    step(1, 0, 0, 0, 0, 1, 11, 7, 0, 0);
    step(1, 9, 1, 0, 0, 1, 9, 3, 0, 1);
    check("mrst_stall", 32'(s_stall), 32'h0);
    check("mrst_busy", s_busy, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
      check("post_wbv", 32'(s_wbv), 32'h0);
      check("r0_stall", 32'(s_stall), 32'h0);
      check("r0_fwd", 32'(s_fwd_rs), 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 12),
           $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
